// File: rtl/disp_pkg.sv
// Shared constants and the BCD-to-segment table for the stopwatch display scanner.
package disp_pkg;

    localparam int unsigned       NUM_DIG   = 8;
    localparam logic [NUM_DIG-1:0] DP_MASK  = 8'b0101_0100;
    localparam logic [6:0]        SEG_DASH  = 7'h40;
    localparam logic [6:0]        SEG_BLANK = 7'h00;

    // Active-high {g,f,e,d,c,b,a}; non-decimal nibbles render as a dash.
    function automatic logic [6:0] seg7_lut(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational nibble-to-segment decoder with blanking, active-high output.
module bcd_to_seg7 (
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);
    import disp_pkg::*;

    always_comb begin
        seg = blank ? SEG_BLANK : seg7_lut(nibble);
    end

endmodule

// File: rtl/bcd_disp_scan.sv
// 8-digit multiplexed 7-segment scanner for a packed-BCD stopwatch word, with
// per-frame snapshot, lap hold, hour blanking, separator dots and dead time.
module bcd_disp_scan #(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned SCAN_HZ        = 1000,
    parameter int unsigned DEAD_CYC       = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] time_data,
    input  logic        hold,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  dig_sel,
    output logic        frame_start
);
    import disp_pkg::*;

    localparam int unsigned DIV    = CLK_FREQ / SCAN_HZ - 1;
    localparam int unsigned DIV_W  = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam int unsigned DEAD_W = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
    localparam int unsigned IDX_W  = $clog2(NUM_DIG);

    logic [DIV_W-1:0]   div_cnt;
    logic [IDX_W-1:0]   dig_idx;
    logic [DEAD_W-1:0]  dead_cnt;
    logic [31:0]        shadow;
    logic               tick;
    logic               last_dig;
    logic [3:0]         nibble;
    logic               blank;
    logic [6:0]         seg_pat;
    logic               dp_pat;
    logic [NUM_DIG-1:0] sel_pat;

    always_comb begin
        tick     = (div_cnt == DIV_W'(DIV));
        last_dig = (dig_idx == IDX_W'(NUM_DIG - 1));
        nibble   = shadow[{dig_idx, 2'b00} +: 4];
        blank    = ((dig_idx == IDX_W'(7)) && (shadow[31:28] == 4'h0))
                || ((dig_idx == IDX_W'(6)) && (shadow[31:24] == 8'h00));
        dp_pat   = DP_MASK[dig_idx] & ~blank;
        sel_pat  = (dead_cnt != '0) ? '0 : (NUM_DIG'(1) << dig_idx);
    end

    bcd_to_seg7 u_dec (
        .nibble (nibble),
        .blank  (blank),
        .seg    (seg_pat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            dig_idx     <= '0;
            dead_cnt    <= '0;
            shadow      <= '0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= tick ? '0 : div_cnt + 1'b1;
            frame_start <= tick && last_dig;
            if (tick) begin
                dig_idx  <= dig_idx + 1'b1;
                dead_cnt <= DEAD_W'(DEAD_CYC);
                // Snapshot on the same edge that wraps to digit 0 so a whole frame
                // comes from one sample.
                if (last_dig && !hold) begin
                    shadow <= time_data;
                end
            end else if (dead_cnt != '0) begin
                dead_cnt <= dead_cnt - 1'b1;
            end
        end
    end

    // Output stage lags the scan state by one clock; polarity applied here only.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg     <= {7{SEG_ACTIVE_LOW}};
            dp      <= SEG_ACTIVE_LOW;
            dig_sel <= {NUM_DIG{DIG_ACTIVE_LOW}};
        end else begin
            seg     <= seg_pat ^ {7{SEG_ACTIVE_LOW}};
            dp      <= dp_pat ^ SEG_ACTIVE_LOW;
            dig_sel <= sel_pat ^ {NUM_DIG{DIG_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Directed bench for bcd_disp_scan: DIV=9, DEAD_CYC=2, one active-high and one active-low instance.
module tb_bcd_disp_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] time_data;
    logic        hold;
    logic [6:0]  seg_p, seg_n;
    logic        dp_p, dp_n;
    logic [7:0]  sel_p, sel_n;
    logic        fs_p, fs_n;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [6:0] cap_seg   [8];
    logic       cap_dp    [8];
    logic [7:0] cap_sel   [8];
    logic [6:0] cap_seg_n [8];
    logic       cap_dp_n  [8];
    logic [7:0] cap_sel_n [8];

    always #5 clk = ~clk;

    bcd_disp_scan #(
        .CLK_FREQ(100), .SCAN_HZ(10), .DEAD_CYC(2),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) u_dut (
        .clk(clk), .rst(rst), .time_data(time_data), .hold(hold),
        .seg(seg_p), .dp(dp_p), .dig_sel(sel_p), .frame_start(fs_p)
    );

    bcd_disp_scan #(
        .CLK_FREQ(100), .SCAN_HZ(10), .DEAD_CYC(2),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) u_inv (
        .clk(clk), .rst(rst), .time_data(time_data), .hold(hold),
        .seg(seg_n), .dp(dp_n), .dig_sel(sel_n), .frame_start(fs_n)
    );

    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;
            4'h3: return 7'h4F;  4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;  4'h8: return 7'h7F;
            4'h9: return 7'h6F;  default: return 7'h40;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after the frame-boundary edge (digit 0 loaded, dead time starting).
    task automatic sync_frame();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            if (fs_p) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL sync_frame: frame_start got 0 for 200 clks, required 1");
        end
    endtask

    // Samples each digit 3 clks after its tick, once its select is live.
    task automatic capture_frame();
        sync_frame();
        for (int k = 0; k < 8; k++) begin
            repeat (k == 0 ? 3 : 10) step();
            cap_seg[k]   = seg_p;  cap_dp[k]   = dp_p;  cap_sel[k]   = sel_p;
            cap_seg_n[k] = seg_n;  cap_dp_n[k] = dp_n;  cap_sel_n[k] = sel_n;
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst = 1'b1; hold = 1'b0; time_data = 32'h12345678;
        repeat (2) step();
        rst = 1'b0;
        repeat (37) step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (seg_p !== 7'h00 || dp_p !== 1'b0 || sel_p !== 8'h00 || fs_p !== 1'b0) begin
                bad++;
                $display("FAIL reset_hi cyc%0d: seg=%h dp=%b sel=%h fs=%b, required 00 0 00 0",
                         i, seg_p, dp_p, sel_p, fs_p);
            end
            total++;
            if (seg_n !== 7'h7F || dp_n !== 1'b1 || sel_n !== 8'hFF) begin
                bad++;
                $display("FAIL reset_lo cyc%0d: seg=%h dp=%b sel=%h, required 7f 1 ff",
                         i, seg_n, dp_n, sel_n);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step();
            exp = (k <= 10) ? 8'h01 : (k <= 12) ? 8'h00 : 8'h02;
            total++;
            if (sel_p !== exp) begin
                bad++;
                $display("FAIL reset_release clk%0d: dig_sel=%b, required %b", k, sel_p, exp);
            end
            if (k == 1) begin
                total++;
                if (seg_p !== 7'h3F || dp_p !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_shadow: seg=%h dp=%b, required 3f 0", seg_p, dp_p);
                end
            end
        end
    endtask

    task automatic test_scan();
        logic [6:0] exp_s [8];
        logic [7:0] dpm;
        int cnt;
        bit got;
        exp_s = '{7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
        dpm = 8'b0101_0100;
        time_data = 32'h12345678;
        capture_frame();
        for (int k = 0; k < 8; k++) begin
            total++;
            if (cap_seg[k] !== exp_s[k] || cap_dp[k] !== dpm[k] || cap_sel[k] !== (8'h01 << k)) begin
                bad++;
                $display("FAIL scan digit%0d: seg=%h dp=%b sel=%b, required %h %b %b",
                         k, cap_seg[k], cap_dp[k], cap_sel[k], exp_s[k], dpm[k], 8'h01 << k);
            end
        end
        sync_frame();
        step();
        total++;
        if (fs_p !== 1'b0) begin
            bad++;
            $display("FAIL fs_width: frame_start=%b one clk later, required 0", fs_p);
        end
        cnt = 1; got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            cnt++;
            if (fs_p) got = 1'b1;
        end
        total++;
        if (!got || cnt != 80) begin
            bad++;
            $display("FAIL frame_period: got %0d clks (seen=%b), required 80", cnt, got);
        end
    endtask

    task automatic test_blank();
        logic [6:0] exp_s [8];
        logic [7:0] dpm;
        exp_s = '{7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F, 7'h3F, 7'h00, 7'h00};
        dpm = 8'b0001_0100;
        time_data = 32'h00001234;
        capture_frame();
        for (int k = 0; k < 8; k++) begin
            total++;
            if (cap_seg[k] !== exp_s[k] || cap_dp[k] !== dpm[k]) begin
                bad++;
                $display("FAIL blank_a digit%0d: seg=%h dp=%b, required %h %b",
                         k, cap_seg[k], cap_dp[k], exp_s[k], dpm[k]);
            end
        end
        time_data = 32'h01000000;
        capture_frame();
        total++;
        if (cap_seg[7] !== 7'h00 || cap_dp[7] !== 1'b0 || cap_sel[7] !== 8'h80) begin
            bad++;
            $display("FAIL blank_b digit7: seg=%h dp=%b sel=%b, required 00 0 10000000",
                     cap_seg[7], cap_dp[7], cap_sel[7]);
        end
        total++;
        if (cap_seg[6] !== 7'h06 || cap_dp[6] !== 1'b1) begin
            bad++;
            $display("FAIL blank_b digit6: seg=%h dp=%b, required 06 1", cap_seg[6], cap_dp[6]);
        end
        total++;
        if (cap_seg[5] !== 7'h3F) begin
            bad++;
            $display("FAIL blank_b digit5: seg=%h, required 3f", cap_seg[5]);
        end
    endtask

    task automatic test_hold();
        hold = 1'b0;
        time_data = 32'h00000099;
        capture_frame();
        hold = 1'b1;
        time_data = 32'h00000100;
        for (int f = 0; f < 3; f++) begin
            capture_frame();
            total++;
            if (cap_seg[0] !== 7'h6F || cap_seg[1] !== 7'h6F || cap_seg[2] !== 7'h3F) begin
                bad++;
                $display("FAIL hold frame%0d: d0=%h d1=%h d2=%h, required 6f 6f 3f",
                         f, cap_seg[0], cap_seg[1], cap_seg[2]);
            end
        end
        sync_frame();
        repeat (13) step();
        hold = 1'b0;
        repeat (10) step();
        total++;
        if (seg_p !== 7'h3F || sel_p !== 8'h04) begin
            bad++;
            $display("FAIL hold_midframe: seg=%h sel=%b, required 3f 00000100", seg_p, sel_p);
        end
        capture_frame();
        total++;
        if (cap_seg[0] !== 7'h3F || cap_seg[1] !== 7'h3F || cap_seg[2] !== 7'h06 || cap_seg[3] !== 7'h3F) begin
            bad++;
            $display("FAIL hold_release: d0=%h d1=%h d2=%h d3=%h, required 3f 3f 06 3f",
                     cap_seg[0], cap_seg[1], cap_seg[2], cap_seg[3]);
        end
    endtask

    task automatic test_tearing();
        logic [3:0] v, prev, samp;
        logic [7:0] exp;
        int off;
        bit got, done;
        v = 4'd1; samp = 4'd0; off = 0; got = 1'b0; done = 1'b0;
        hold = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            time_data = {8{v}};
            prev = v;
            v = (v == 4'd9) ? 4'd1 : v + 4'd1;
            step();
            if (!got) begin
                if (fs_p) begin
                    got = 1'b1; samp = prev; off = 0;
                end
            end else begin
                off++;
            end
            total++;
            if (!$onehot0(sel_p)) begin
                bad++;
                $display("FAIL onehot0 cyc%0d: dig_sel=%b, required at most one bit", c, sel_p);
            end
            if (got) begin
                if (off % 10 == 1 || off % 10 == 2) exp = 8'h00;
                else if (off == 0)                  exp = 8'h80;
                else if (off % 10 == 0)             exp = 8'h01 << (off / 10 - 1);
                else                                exp = 8'h01 << (off / 10);
                total++;
                if (sel_p !== exp) begin
                    bad++;
                    $display("FAIL dead_time off%0d: dig_sel=%b, required %b", off, sel_p, exp);
                end
                if (off % 10 == 3) begin
                    total++;
                    if (seg_p !== exp_seg(samp)) begin
                        bad++;
                        $display("FAIL tearing digit%0d: seg=%h, required %h (sample %0d)",
                                 off / 10, seg_p, exp_seg(samp), samp);
                    end
                end
                if (off == 79) done = 1'b1;
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL tearing_timeout: frame seen=%b, required 1", got);
        end
    endtask

    task automatic test_invalid();
        time_data = 32'h0000000C;
        capture_frame();
        total++;
        if (cap_seg[0] !== 7'h40) begin
            bad++;
            $display("FAIL invalid_hi: seg=%h, required 40", cap_seg[0]);
        end
        total++;
        if (cap_seg_n[0] !== 7'h3F || cap_sel_n[0] !== 8'hFE || cap_dp_n[0] !== 1'b1) begin
            bad++;
            $display("FAIL invalid_lo d0: seg=%h sel=%h dp=%b, required 3f fe 1",
                     cap_seg_n[0], cap_sel_n[0], cap_dp_n[0]);
        end
        total++;
        if (cap_seg_n[7] !== 7'h7F || cap_sel_n[3] !== 8'hF7 || cap_dp_n[2] !== 1'b0) begin
            bad++;
            $display("FAIL polarity_lo: d7seg=%h d3sel=%h d2dp=%b, required 7f f7 0",
                     cap_seg_n[7], cap_sel_n[3], cap_dp_n[2]);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank();
        test_hold();
        test_tearing();
        test_invalid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at 5 ms, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
